// File: rtl/weight_fetch_ctrl.sv
// Weight-fetch sequencer: issues a layer's weights as fixed-length AXI read bursts,
// bounds outstanding bursts, throttles on weight-buffer space and checks R-channel framing.
module weight_fetch_ctrl #(
  parameter int AW       = 32,
  parameter int BURST    = 16,
  parameter int ADDR_INC = 16,
  parameter int MAX_OUT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [CNT_W-1:0] num_bursts,
  input  logic             buf_ready,
  output logic [AW-1:0]    araddr,
  output logic             arvalid,
  output logic [3:0]       arlen,
  input  logic             arready,
  input  logic             rvalid,
  input  logic             rlast,
  output logic             rready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       dbg_state_o
);

  // AR channel: once arvalid rises, arvalid and araddr hold until arready is seen high
  // on a clock edge; a transfer happens on any edge where both are high.
  // R channel: rready mirrors busy; a beat is taken on any edge with rvalid && rready.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
  localparam logic [AW-1:0] INC_C     = AW'(ADDR_INC);

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             arvalid_q, arvalid_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] completed_q, completed_d;
  logic [OW-1:0]    outstanding_q, outstanding_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             busy_w;
  logic             beat_acc, stray, beat_ok, at_last, comp, frame_err, ar_hs, can_issue;
  logic [CNT_W-1:0] issued_n, completed_n;
  logic [OW-1:0]    outstanding_n;

  assign busy_w = (state_q != S_IDLE);

  always_comb begin
    beat_acc      = rvalid && busy_w;
    stray         = beat_acc && (outstanding_q == '0);
    beat_ok       = beat_acc && !stray;
    at_last       = (beat_q == LAST_BEAT);
    // A full-length burst without rlast still closes the burst so counts stay aligned.
    comp          = beat_ok && (rlast || at_last);
    frame_err     = beat_ok && (rlast != at_last);
    ar_hs         = arvalid_q && arready;
    issued_n      = issued_q + CNT_W'(ar_hs);
    completed_n   = completed_q + CNT_W'(comp);
    outstanding_n = outstanding_q + OW'(ar_hs) - OW'(comp);
    can_issue     = (issued_n < num_q) && (outstanding_n < MAX_OUT_C) && buf_ready;
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    arvalid_d     = arvalid_q;
    num_d         = num_q;
    issued_d      = issued_n;
    completed_d   = completed_n;
    outstanding_d = outstanding_n;
    beat_d        = beat_q;
    err_d         = err_q | frame_err | stray;
    done_d        = 1'b0;

    if (beat_ok) begin
      beat_d = comp ? '0 : beat_q + BW'(1);
    end
    if (ar_hs) begin
      addr_d = addr_q + INC_C;
    end

    case (state_q)
      S_IDLE: begin
        arvalid_d = 1'b0;
        if (start) begin
          addr_d        = base_addr;
          num_d         = num_bursts;
          issued_d      = '0;
          completed_d   = '0;
          outstanding_d = '0;
          beat_d        = '0;
          err_d         = 1'b0;
          if (num_bursts == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = S_ISSUE;
            arvalid_d = buf_ready;
          end
        end
      end
      S_ISSUE: begin
        if (!arvalid_q || arready) begin
          arvalid_d = can_issue;
        end
        if (issued_n == num_q) begin
          if (completed_n == num_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        arvalid_d = 1'b0;
        if (completed_n == num_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      arvalid_q     <= 1'b0;
      num_q         <= '0;
      issued_q      <= '0;
      completed_q   <= '0;
      outstanding_q <= '0;
      beat_q        <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      arvalid_q     <= arvalid_d;
      num_q         <= num_d;
      issued_q      <= issued_d;
      completed_q   <= completed_d;
      outstanding_q <= outstanding_d;
      beat_q        <= beat_d;
      err_q         <= err_d;
      done_q        <= done_d;
    end
  end

  assign araddr      = addr_q;
  assign arvalid     = arvalid_q;
  assign arlen       = 4'(BURST - 1);
  assign rready      = busy_w;
  assign busy        = busy_w;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: table of layer runs plus hand-written corner sequences,
// with an AR address scoreboard and a negedge AXI slave model.
module tb_weight_fetch_ctrl;

  localparam int BURST   = 16;
  localparam int MAX_OUT = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_bursts = '0;
  logic        buf_ready = 1'b0;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0;
  logic        rlast = 1'b0;
  logic [31:0] araddr;
  logic        arvalid, rready, busy, done, err;
  logic [3:0]  arlen;
  logic [1:0]  dbg_state;

  weight_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_bursts(num_bursts), .buf_ready(buf_ready), .araddr(araddr),
    .arvalid(arvalid), .arlen(arlen), .arready(arready), .rvalid(rvalid),
    .rlast(rlast), .rready(rready), .busy(busy), .done(done), .err(err),
    .dbg_state_o(dbg_state)
  );

  // scoreboard and counters
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_err = 0;

  // slave-model controls (written by main only)
  int ar_mode = 0;   // 0 always ready, 1 random, 2 held low
  int buf_mode = 1;  // 0 low, 1 high, 2 random
  int r_mode = 0;    // 0 clean, 1 early rlast on beat 10, 2 no rlast on beat 16
  int r_en = 0;
  int r_limit = 1 << 30;
  int bad_idx = 0;

  // slave-model state (written by monitor only)
  int cyc = 0;
  int hs_cnt = 0, hs_cyc = 0;
  int done_cnt = 0, done_cyc = 0;
  int comp_cyc = 0, r_done_cnt = 0;
  int out_m = 0, rbeat = 0;
  bit prev_wait = 0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs chosen here are sampled by the next posedge, so handshakes are scored here.
  always @(negedge clk) begin : mon
    bit hs, bad;
    int end_beat;
    cyc++;
    if (!rst_n) begin
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      out_m = 0; rbeat = 0; prev_wait = 0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_wait) begin
        chk("ar_hold_valid", 32'(arvalid), 32'd1);
        chk("ar_hold_addr", araddr, prev_addr);
      end
      if (arvalid) chk("ar_within_limit", 32'(out_m < MAX_OUT), 32'd1);

      case (ar_mode)
        0: arready = 1'b1;
        1: arready = 1'($urandom_range(0, 1));
        default: arready = 1'b0;
      endcase
      case (buf_mode)
        0: buf_ready = 1'b0;
        1: buf_ready = 1'b1;
        default: buf_ready = 1'($urandom_range(0, 1));
      endcase

      if (r_en != 0 && out_m > 0 && r_done_cnt < r_limit) begin
        bad = (r_mode != 0) && (r_done_cnt == bad_idx);
        end_beat = (bad && r_mode == 1) ? 9 : BURST - 1;
        rvalid = 1'b1;
        rlast = (rbeat == end_beat) && !(bad && r_mode == 2);
        if (rready) begin
          if (rbeat == end_beat) begin
            rbeat = 0;
            out_m--;
            r_done_cnt++;
            comp_cyc = cyc;
          end else begin
            rbeat++;
          end
        end
      end else begin
        rvalid = 1'b0;
        rlast = 1'b0;
      end

      hs = arvalid && arready;
      if (hs) begin
        if (exp_q.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
        else chk("araddr", araddr, exp_q.pop_front());
        hs_cnt++;
        hs_cyc = cyc;
        out_m++;
      end
      prev_wait = arvalid && !arready;
      prev_addr = araddr;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_done(input int d0, input string name);
    int to = 0;
    while (done_cnt == d0 && to < 4000) begin
      step(1);
      to++;
    end
    chk(name, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic pulse_start(input logic [31:0] base, input int num, output int s_cyc);
    start = 1'b1;
    base_addr = base;
    num_bursts = 16'(num);
    s_cyc = cyc + 1;
    step(1);
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] base;
    int          num;
    int          arm;
    int          bufm;
    int          rm;
    logic        exp_err;
    int          exp_last_hs;  // handshake cycle of last AR relative to start, 0 = unchecked
  } vec_t;

  task automatic run_layer(input vec_t v, input string tag);
    int hs0, d0, s_cyc;
    ar_mode = v.arm; buf_mode = v.bufm; r_mode = v.rm;
    r_en = 1; r_limit = 1 << 30; bad_idx = r_done_cnt;
    hs0 = hs_cnt; d0 = done_cnt;
    for (int i = 0; i < v.num; i++) exp_q.push_back(v.base + 32'(i * 16));
    pulse_start(v.base, v.num, s_cyc);
    wait_done(d0, {tag, "_done"});
    chk({tag, "_hs_count"}, 32'(hs_cnt - hs0), 32'(v.num));
    chk({tag, "_exp_q_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    if (v.num == 0) chk({tag, "_done_latency"}, 32'(done_cyc - s_cyc), 32'd1);
    else chk({tag, "_done_after_rlast"}, 32'(done_cyc - comp_cyc), 32'd1);
    if (v.exp_last_hs != 0) chk({tag, "_last_ar_cycle"}, 32'(hs_cyc - s_cyc), 32'(v.exp_last_hs));
    exp_q.delete();
  endtask

  vec_t vecs[7];

  initial begin
    int hs0, d0, s_cyc, to;
    vec_t v;
    vecs[0] = '{32'h0000_1000, 3, 0, 1, 0, 1'b0, 3};
    vecs[1] = '{32'h0000_2000, 5, 1, 2, 0, 1'b0, 0};
    vecs[2] = '{32'hFFFF_FFF0, 2, 0, 1, 0, 1'b0, 2};
    vecs[3] = '{32'h0000_3000, 4, 0, 1, 1, 1'b1, 4};
    vecs[4] = '{32'h0000_5000, 0, 0, 1, 0, 1'b0, 0};
    vecs[5] = '{32'h0000_4000, 2, 0, 1, 2, 1'b1, 2};
    vecs[6] = '{32'h0000_6000, 8, 1, 2, 0, 1'b0, 0};

    // reset state
    step(3);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("arlen_const", 32'(arlen), 32'(BURST - 1));
    rst_n = 1'b1;
    step(2);

    for (int i = 0; i < 7; i++) run_layer(vecs[i], $sformatf("vec%0d", i));

    // backpressure, buf_ready throttling, start ignored during ISSUE
    ar_mode = 2; buf_mode = 1; r_en = 0; r_mode = 0;
    step(1);
    hs0 = hs_cnt; d0 = done_cnt;
    exp_q.push_back(32'h0000_7000);
    exp_q.push_back(32'h0000_7010);
    pulse_start(32'h0000_7000, 2, s_cyc);
    chk("bp_busy_cycle1", 32'(busy), 32'd1);
    chk("bp_rready_eq_busy", 32'(rready), 32'd1);
    chk("bp_arvalid_cycle1", 32'(arvalid), 32'd1);
    chk("bp_araddr_cycle1", araddr, 32'h0000_7000);
    step(2);
    buf_mode = 0;
    step(3);
    chk("bp_still_waiting", 32'(hs_cnt - hs0), 32'd0);
    ar_mode = 0;
    step(5);
    chk("bp_one_hs", 32'(hs_cnt - hs0), 32'd1);
    chk("bp_no_arvalid_buf_low", 32'(arvalid), 32'd0);
    start = 1'b1; base_addr = 32'hDEAD_0000; num_bursts = 16'd7;
    step(1);
    start = 1'b0;
    chk("bp_start_ignored_state", 32'(dbg_state), 32'(ST_ISSUE));
    buf_mode = 1; r_en = 1; r_limit = 1 << 30;
    wait_done(d0, "bp_done");
    chk("bp_hs_total", 32'(hs_cnt - hs0), 32'd2);
    chk("bp_exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_err", 32'(err), 32'd0);
    exp_q.delete();

    // outstanding limit
    ar_mode = 0; buf_mode = 1; r_en = 1; r_mode = 0; r_limit = r_done_cnt;
    hs0 = hs_cnt; d0 = done_cnt;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h0000_8000 + 32'(i * 16));
    pulse_start(32'h0000_8000, 8, s_cyc);
    step(20);
    chk("lim_hs_capped", 32'(hs_cnt - hs0), 32'(MAX_OUT));
    chk("lim_arvalid_low", 32'(arvalid), 32'd0);
    r_limit = r_done_cnt + 1;
    to = 0;
    while (r_done_cnt < r_limit && to < 100) begin
      step(1);
      to++;
    end
    chk("lim_burst_completed", 32'(r_done_cnt == r_limit), 32'd1);
    step(2);
    chk("lim_fifth_hs", 32'(hs_cnt - hs0), 32'(MAX_OUT + 1));
    chk("lim_fifth_hs_cycle", 32'(hs_cyc - comp_cyc), 32'd1);
    r_limit = 1 << 30;
    wait_done(d0, "lim_done");
    chk("lim_hs_total", 32'(hs_cnt - hs0), 32'd8);
    chk("lim_err", 32'(err), 32'd0);
    exp_q.delete();

    // reset mid-DRAIN
    r_limit = r_done_cnt + 1;
    hs0 = hs_cnt;
    exp_q.push_back(32'h0000_9000);
    exp_q.push_back(32'h0000_9010);
    pulse_start(32'h0000_9000, 2, s_cyc);
    step(25);
    chk("rd_in_drain", 32'(dbg_state), 32'(ST_DRAIN));
    #1 rst_n = 1'b0;
    #1;
    chk("rd_arvalid", 32'(arvalid), 32'd0);
    chk("rd_araddr", araddr, 32'd0);
    chk("rd_rready", 32'(rready), 32'd0);
    chk("rd_busy", 32'(busy), 32'd0);
    chk("rd_err", 32'(err), 32'd0);
    chk("rd_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    r_limit = 1 << 30;
    hs0 = hs_cnt;
    step(5);
    chk("rd_no_reissue", 32'(hs_cnt - hs0), 32'd0);
    chk("rd_idle_after", 32'(busy), 32'd0);
    v = '{32'h0000_A000, 3, 0, 1, 0, 1'b0, 3};
    run_layer(v, "after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/weight_fetch_ctrl.md
# weight_fetch_ctrl

Sequencer for depthwise/pointwise weight loading. Fetches one layer's weights as a run of fixed-length read bursts and drives the AXI read-address channel with a compliant valid/ready handshake. It bounds outstanding bursts and throttles issue on weight-buffer space. It checks read-data burst framing and reports completion to the layer controller.

## Interface
Parameters:
- AW, 32, address width
- BURST, 16, beats per burst (power of two, 2..16)
- ADDR_INC, 16, byte increment between consecutive burst addresses
- MAX_OUT, 4, maximum outstanding (address-accepted, rlast-not-yet-seen) bursts
- CNT_W, 16, width of burst counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle pulse; latches base_addr/num_bursts; honoured only in IDLE
- base_addr  in  AW  first burst address
- num_bursts  in  CNT_W  bursts to fetch for this layer
- buf_ready  in  1  weight buffer can accept one more full burst
- araddr  out  AW  read address
- arvalid  out  1  read address valid
- arlen  out  4  constant BURST-1
- arready  in  1  read address accepted
- rvalid  in  1  read data beat valid
- rlast  in  1  last beat of burst
- rready  out  1  read data accept
- busy  out  1  high in ISSUE or DRAIN
- done  out  1  one-cycle completion pulse
- err  out  1  sticky framing error, cleared by accepted start

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: accepted start loads addr=base_addr and clears issued, completed, outstanding, beat_cnt, and err.
  - num_bursts==0: done=1 the next cycle; stay IDLE; no AR issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - Raise arvalid when issued<num_bursts, outstanding<MAX_OUT, and buf_ready=1.
  - Once raised, arvalid and araddr hold stable until arready, regardless of buf_ready.
  - On AR handshake: issued+1, outstanding+1, addr+=ADDR_INC modulo 2^AW (wrap silently).
  - Go to DRAIN when issued==num_bursts and no AR is pending.
- rready=busy. A beat is accepted on rvalid&rready.
- beat_cnt counts accepted beats within a burst and resets after each rlast beat.
- Burst completion on accepted rlast: completed+1, outstanding-1.
  - AR handshake and rlast in the same cycle leave outstanding unchanged.
- Framing error, sets err:
  - rlast on a beat other than beat BURST.
  - Beat BURST without rlast. Treat it as end of burst anyway so counts stay consistent.
- Beats accepted while outstanding==0: set err, ignore them.
- DRAIN: when completed==num_bursts, assert done for one cycle and return to IDLE.
- start outside IDLE is ignored (no relatch, no err).
- Reset values: arvalid=0, araddr=0, rready=0, busy=0, done=0, err=0, state=IDLE, all counters 0.
- Reset mid-operation clears everything immediately. No AR is reissued; any later beats are not accepted.

## Timing
- start at cycle 0 -> busy and earliest arvalid at cycle 1. All outputs are registered.
- Back-to-back issue: after a handshake at cycle k, the next arvalid can be high at cycle k+1 with araddr+ADDR_INC.
- When outstanding==MAX_OUT, a completion at cycle k allows arvalid at cycle k+1.
- Final accepted rlast at cycle k -> done=1 at k+1, busy=0 at k+1, IDLE at k+1. A new start is accepted at k+1.
- num_bursts==0: start at cycle 0 -> done at cycle 1.
- err is visible the cycle after the offending beat.

## Test plan
- Basic run: base=0x1000, num=3, arready and rvalid always 1, 16-beat bursts -> araddr 0x1000, 0x1010, 0x1020 on consecutive handshakes; done one cycle after third rlast; err=0.
- Backpressure: arready low 5 cycles with arvalid up -> araddr/arvalid stable throughout. buf_ready dropped while arvalid high -> request still completes. buf_ready=0 before issue -> no arvalid.
- Outstanding limit: num=8, MAX_OUT=4, no R data -> exactly 4 AR handshakes, then arvalid=0. One rlast burst -> 5th AR next cycle.
- Edge counts: num=0 -> done at cycle 1, no arvalid. base=0xFFFFFFF0, num=2 -> second araddr=0x00000000.
- Framing: rlast on beat 10 -> err=1 next cycle, persists through done, cleared by next start. 16 beats without rlast -> err=1.
- Robustness: start during ISSUE -> ignored. Simultaneous AR handshake and rlast -> outstanding unchanged. rst_n asserted mid-DRAIN -> all outputs 0 immediately, IDLE; next start runs normally.
